// File: rtl/ctrl_mc_if.sv
`default_nettype none
// ============================================================================
// Module   : ctrl_mc_if
// Brief    : Control bus between the multi-cycle MIPS controller and datapath.
// Revision : 1.0 - initial release
// ============================================================================
interface ctrl_mc_if;
    logic [5:0] opcode;
    logic       zero;
    logic       mem_ready;
    logic       pc_ce;
    logic       ir_ce;
    logic       IorD;
    logic       MemRead;
    logic       MemWrite;
    logic       MemtoReg;
    logic       RegDst;
    logic       RegWrite;
    logic       ALUSrcA;
    logic [1:0] ALUSrcB;
    logic [1:0] ALUOp;
    logic [1:0] PCSource;
    logic [3:0] state;

    modport master (
        input  opcode, zero, mem_ready,
        output pc_ce, ir_ce, IorD, MemRead, MemWrite, MemtoReg, RegDst,
               RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSource, state
    );

    modport slave (
        output opcode, zero, mem_ready,
        input  pc_ce, ir_ce, IorD, MemRead, MemWrite, MemtoReg, RegDst,
               RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSource, state
    );
endinterface
`default_nettype wire

// File: rtl/ctrl_mc.sv
`default_nettype none
// ============================================================================
// Module   : ctrl_mc
// Brief    : Multi-cycle MIPS control FSM with memory-ready stall handshake.
// Revision : 1.0 - initial release
// ============================================================================
module ctrl_mc (
    input  wire logic clk,
    input  wire logic rst,
    ctrl_mc_if.master bus
);
    typedef enum logic [3:0] {
        S_IF   = 4'd0,
        S_ID   = 4'd1,
        S_MADR = 4'd2,
        S_MRD  = 4'd3,
        S_MWB  = 4'd4,
        S_MWR  = 4'd5,
        S_EXE  = 4'd6,
        S_RWB  = 4'd7,
        S_BEQ  = 4'd8,
        S_JMP  = 4'd9,
        S_AEXE = 4'd10,
        S_AWB  = 4'd11
    } state_t;

    localparam logic [5:0] c_OP_RTYPE = 6'b000000;
    localparam logic [5:0] c_OP_LW    = 6'b100011;
    localparam logic [5:0] c_OP_SW    = 6'b101011;
    localparam logic [5:0] c_OP_BEQ   = 6'b000100;
    localparam logic [5:0] c_OP_J     = 6'b000010;
    localparam logic [5:0] c_OP_ADDI  = 6'b001000;

    state_t     r_state;
    state_t     w_next;
    logic       w_pcwrite;
    logic       w_pcwritecond;
    logic       w_ir_ce;
    logic       w_iord;
    logic       w_memread;
    logic       w_memwrite;
    logic       w_memtoreg;
    logic       w_regdst;
    logic       w_regwrite;
    logic       w_alusrca;
    logic [1:0] w_alusrcb;
    logic [1:0] w_aluop;
    logic [1:0] w_pcsource;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IF;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next        = S_IF;
        w_pcwrite     = 1'b0;
        w_pcwritecond = 1'b0;
        w_ir_ce       = 1'b0;
        w_iord        = 1'b0;
        w_memread     = 1'b0;
        w_memwrite    = 1'b0;
        w_memtoreg    = 1'b0;
        w_regdst      = 1'b0;
        w_regwrite    = 1'b0;
        w_alusrca     = 1'b0;
        w_alusrcb     = 2'b00;
        w_aluop       = 2'b00;
        w_pcsource    = 2'b00;
        case (r_state)
            S_IF: begin
                w_memread = 1'b1;
                w_alusrcb = 2'b01;
                w_ir_ce   = bus.mem_ready;
                w_pcwrite = bus.mem_ready;
                if (bus.mem_ready) begin
                    w_next = S_ID;
                end else begin
                    w_next = S_IF;
                end
            end
            S_ID: begin
                w_alusrcb = 2'b11;
                case (bus.opcode)
                    c_OP_RTYPE:       w_next = S_EXE;
                    c_OP_LW, c_OP_SW: w_next = S_MADR;
                    c_OP_BEQ:         w_next = S_BEQ;
                    c_OP_J:           w_next = S_JMP;
                    c_OP_ADDI:        w_next = S_AEXE;
                    default:          w_next = S_IF;
                endcase
            end
            S_MADR: begin
                w_alusrca = 1'b1;
                w_alusrcb = 2'b10;
                if (bus.opcode == c_OP_LW) begin
                    w_next = S_MRD;
                end else if (bus.opcode == c_OP_SW) begin
                    w_next = S_MWR;
                end else begin
                    w_next = S_IF;
                end
            end
            S_MRD: begin
                w_memread = 1'b1;
                w_iord    = 1'b1;
                if (bus.mem_ready) begin
                    w_next = S_MWB;
                end else begin
                    w_next = S_MRD;
                end
            end
            S_MWB: begin
                w_regwrite = 1'b1;
                w_memtoreg = 1'b1;
            end
            S_MWR: begin
                w_memwrite = 1'b1;
                w_iord     = 1'b1;
                if (bus.mem_ready) begin
                    w_next = S_IF;
                end else begin
                    w_next = S_MWR;
                end
            end
            S_EXE: begin
                w_alusrca = 1'b1;
                w_aluop   = 2'b10;
                w_next    = S_RWB;
            end
            S_RWB: begin
                w_regwrite = 1'b1;
                w_regdst   = 1'b1;
            end
            S_BEQ: begin
                w_alusrca     = 1'b1;
                w_aluop       = 2'b01;
                w_pcwritecond = 1'b1;
                w_pcsource    = 2'b01;
            end
            S_JMP: begin
                w_pcwrite  = 1'b1;
                w_pcsource = 2'b10;
            end
            S_AEXE: begin
                w_alusrca = 1'b1;
                w_alusrcb = 2'b10;
                w_next    = S_AWB;
            end
            S_AWB: begin
                w_regwrite = 1'b1;
            end
            default: begin
                w_next = S_IF;
            end
        endcase
    end

    // While reset is held the IF decode must not leak onto the bus.
    assign bus.pc_ce    = ~rst & (w_pcwrite | (w_pcwritecond & bus.zero));
    assign bus.ir_ce    = ~rst & w_ir_ce;
    assign bus.IorD     = ~rst & w_iord;
    assign bus.MemRead  = ~rst & w_memread;
    assign bus.MemWrite = ~rst & w_memwrite;
    assign bus.MemtoReg = ~rst & w_memtoreg;
    assign bus.RegDst   = ~rst & w_regdst;
    assign bus.RegWrite = ~rst & w_regwrite;
    assign bus.ALUSrcA  = ~rst & w_alusrca;
    assign bus.ALUSrcB  = rst ? 2'b00 : w_alusrcb;
    assign bus.ALUOp    = rst ? 2'b00 : w_aluop;
    assign bus.PCSource = rst ? 2'b00 : w_pcsource;
    assign bus.state    = r_state;
endmodule
`default_nettype wire

// File: tb/tb_ctrl_mc.sv
`default_nettype none
// ============================================================================
// Module   : tb_ctrl_mc
// Brief    : Scoreboard bench for ctrl_mc driven by an instruction-level model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ctrl_mc;
    localparam int S_IF = 0, S_ID = 1, S_MADR = 2, S_MRD = 3, S_MWB = 4, S_MWR = 5;
    localparam int S_EXE = 6, S_RWB = 7, S_BEQ = 8, S_JMP = 9, S_AEXE = 10, S_AWB = 11;
    localparam logic [5:0] c_OP_R = 6'b000000, c_OP_LW = 6'b100011, c_OP_SW = 6'b101011;
    localparam logic [5:0] c_OP_BEQ = 6'b000100, c_OP_J = 6'b000010, c_OP_ADDI = 6'b001000;

    logic clk;
    logic rst;
    ctrl_mc_if bus ();

    ctrl_mc dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [18:0] exp_q[$];
    int n_vec = 0;
    int n_err = 0;
    int n_idx = 0;

    function automatic logic [18:0] actual();
        return {bus.pc_ce, bus.ir_ce, bus.IorD, bus.MemRead, bus.MemWrite,
                bus.MemtoReg, bus.RegDst, bus.RegWrite, bus.ALUSrcA,
                bus.ALUSrcB, bus.ALUOp, bus.PCSource, bus.state};
    endfunction

    // Expected bus word for one cycle in state s, straight from the state table.
    function automatic logic [18:0] exp_word(int s, bit mr, bit z);
        logic pcw, pcwc, irce, iord, mrd, mwr, m2r, rdst, rw, asa;
        logic [1:0] asb, aop, psrc;
        {pcw, pcwc, irce, iord, mrd, mwr, m2r, rdst, rw, asa} = '0;
        {asb, aop, psrc} = '0;
        case (s)
            S_IF:           begin mrd = 1; asb = 2'b01; irce = mr; pcw = mr; end
            S_ID:           asb = 2'b11;
            S_MADR, S_AEXE: begin asa = 1; asb = 2'b10; end
            S_MRD:          begin mrd = 1; iord = 1; end
            S_MWB:          begin rw = 1; m2r = 1; end
            S_MWR:          begin mwr = 1; iord = 1; end
            S_EXE:          begin asa = 1; aop = 2'b10; end
            S_RWB:          begin rw = 1; rdst = 1; end
            S_BEQ:          begin asa = 1; aop = 2'b01; pcwc = 1; psrc = 2'b01; end
            S_JMP:          begin pcw = 1; psrc = 2'b10; end
            S_AWB:          rw = 1;
            default:        ;
        endcase
        return {pcw | (pcwc & z), irce, iord, mrd, mwr, m2r, rdst, rw, asa,
                asb, aop, psrc, 4'(s)};
    endfunction

    function automatic bit rbit();
        return 1'($urandom);
    endfunction

    task automatic check(string name, logic [18:0] got, logic [18:0] req);
        n_vec++;
        if (got !== req) begin
            n_err++;
            $display("FAIL %s: got %b, required %b", name, got, req);
        end
    endtask

    task automatic drive(int s, bit mr, logic [5:0] op, bit z);
        @(posedge clk);
        #1;
        rst           = 1'b0;
        bus.mem_ready = mr;
        bus.opcode    = op;
        bus.zero      = z;
        exp_q.push_back(exp_word(s, mr, z));
    endtask

    // One instruction: the state path follows from the opcode, stalls add waits.
    task automatic run_instr(logic [5:0] op, bit z, int sif, int smem);
        for (int i = 0; i < sif; i++) drive(S_IF, 1'b0, 6'($urandom), rbit());
        drive(S_IF, 1'b1, 6'($urandom), rbit());
        drive(S_ID, rbit(), op, rbit());
        case (op)
            c_OP_R: begin
                drive(S_EXE, rbit(), op, rbit());
                drive(S_RWB, rbit(), op, rbit());
            end
            c_OP_LW: begin
                drive(S_MADR, rbit(), op, rbit());
                for (int i = 0; i < smem; i++) drive(S_MRD, 1'b0, op, rbit());
                drive(S_MRD, 1'b1, op, rbit());
                drive(S_MWB, rbit(), op, rbit());
            end
            c_OP_SW: begin
                drive(S_MADR, rbit(), op, rbit());
                for (int i = 0; i < smem; i++) drive(S_MWR, 1'b0, op, rbit());
                drive(S_MWR, 1'b1, op, rbit());
            end
            c_OP_BEQ:  drive(S_BEQ, rbit(), op, z);
            c_OP_J:    drive(S_JMP, rbit(), op, rbit());
            c_OP_ADDI: begin
                drive(S_AEXE, rbit(), op, rbit());
                drive(S_AWB, rbit(), op, rbit());
            end
            default: ;
        endcase
    endtask

    initial begin : monitor
        logic [18:0] e;
        forever begin
            @(negedge clk);
            if (!rst && exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check($sformatf("trace[%0d]", n_idx), actual(), e);
                n_idx++;
            end
        end
    end

    initial begin : stim
        logic [5:0] ops[6];
        logic [5:0] op;
        ops = '{c_OP_R, c_OP_LW, c_OP_SW, c_OP_BEQ, c_OP_J, c_OP_ADDI};
        rst           = 1'b1;
        bus.mem_ready = 1'b1;
        bus.opcode    = 6'b000000;
        bus.zero      = 1'b1;
        #2;
        check("reset_outputs", actual(), 19'd0);
        @(negedge clk);
        check("reset_hold", actual(), 19'd0);

        run_instr(c_OP_R,    1'b0, 0, 0);
        run_instr(c_OP_LW,   1'b0, 2, 2);
        run_instr(c_OP_SW,   1'b0, 0, 0);
        run_instr(c_OP_BEQ,  1'b1, 0, 0);
        run_instr(c_OP_BEQ,  1'b0, 0, 0);
        run_instr(c_OP_J,    1'b0, 0, 0);
        run_instr(c_OP_ADDI, 1'b0, 0, 0);
        run_instr(6'b111111, 1'b0, 0, 0);

        for (int n = 0; n < 150; n++) begin
            if ($urandom_range(0, 6) == 0) begin
                do op = 6'($urandom);
                while (op inside {c_OP_R, c_OP_LW, c_OP_SW, c_OP_BEQ, c_OP_J, c_OP_ADDI});
            end else begin
                op = ops[$urandom_range(0, 5)];
            end
            run_instr(op, rbit(), $urandom_range(0, 3), $urandom_range(0, 3));
        end

        // lw caught mid memory wait, then reset asynchronously.
        drive(S_IF,   1'b1, 6'($urandom), 1'b0);
        drive(S_ID,   1'b1, c_OP_LW, 1'b0);
        drive(S_MADR, 1'b1, c_OP_LW, 1'b0);
        drive(S_MRD,  1'b0, c_OP_LW, 1'b0);
        drive(S_MRD,  1'b0, c_OP_LW, 1'b0);
        @(negedge clk);
        #2;
        bus.mem_ready = 1'b1;
        rst = 1'b1;
        #1;
        check("reset_async", actual(), 19'd0);
        repeat (2) begin
            @(negedge clk);
            check("reset_mid_hold", actual(), 19'd0);
        end
        run_instr(c_OP_SW, 1'b0, 1, 1);

        for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(posedge clk);
        @(negedge clk);
        #1;
        if (exp_q.size() != 0) begin
            n_vec++;
            n_err++;
            $display("FAIL drain: got %0d pending, required 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
`default_nettype wire
